// File: rtl/seq_adder_bcd_display.sv
// seq_adder_bcd_display
//   Registers two WIDTH-bit operands on a start pulse and forms their full
//   WIDTH+1-bit sum. The sum is converted to BCD by shift-add-3, one bit per
//   clock. The result drives a time-multiplexed, active-low 7-segment display
//   with leading-zero blanking.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : operation request, only honoured while idle
//   a, b   : operands, captured when start is accepted
//   busy   : high while the BCD conversion runs
//   done   : one-cycle pulse when a new result reaches the display
//   sum    : registered {carry, a+b}
//   seg    : segment drive {g,f,e,d,c,b,a}, active-low
//   an     : digit enables, active-low one-hot, an[0] = least significant
module seq_adder_bcd_display #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    sum,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned SW     = WIDTH + 1;
  localparam int unsigned BW     = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(SW);
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q;
  logic [SW-1:0]     sum_q;
  logic [SW-1:0]     sum_d;
  logic [SW-1:0]     src_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_d;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     disp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SCAN_W-1:0] scan_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              done_q;

  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic              upper_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign sum_d = SW'(a) + SW'(b);

  // One double-dabble step: correct nibbles >= 5, then shift in the next sum bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[BW-2:0], src_q[SW-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      src_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_q   <= sum_d;
            src_q   <= sum_d;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          src_q <= {src_q[SW-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH)) begin
            // Take the post-shift value so the digits appear with done.
            disp_q  <= bcd_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  // Walk from the top digit down so upper_zero covers the current digit and all above.
  always_comb begin
    upper_zero = 1'b1;
    cur_nib    = '0;
    cur_blank  = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      upper_zero = upper_zero & (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      if (idx_q == IDX_W'(DIGITS - 1 - k)) begin
        cur_nib   = disp_q[4*(DIGITS-1-k) +: 4];
        cur_blank = (k != DIGITS - 1) && upper_zero;
      end
    end
    seg = cur_blank ? 7'b1111111 : seg_decode(cur_nib);
    an  = ~(DIGITS'(1) << idx_q);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule

// File: tb/tb_seq_adder_bcd_display.sv
module tb_seq_adder_bcd_display;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic       busy;
  logic       done;
  logic [8:0] sum;
  logic [6:0] seg;
  logic [2:0] an;

  always #5 clk = ~clk;

  seq_adder_bcd_display #(
    .WIDTH   (8),
    .DIGITS  (3),
    .SCAN_DIV(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .seg  (seg),
    .an   (an)
  );

  typedef struct packed {
    logic [8:0]      sum;
    logic [2:0][6:0] segs;
  } sb_t;

  sb_t             sb_q[$];
  int unsigned     checks = 0;
  int unsigned     errors = 0;
  logic [2:0][6:0] last_disp;

  function automatic logic [6:0] model_seg(input int unsigned v, input int unsigned d);
    int unsigned p;
    int unsigned dig;
    p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    dig = (v / p) % 10;
    if (d != 0 && v < p) return 7'b1111111;
    case (dig)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0][6:0] model_disp(input int unsigned v);
    logic [2:0][6:0] r;
    for (int unsigned d = 0; d < 3; d++) r[d] = model_seg(v, d);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned av, input int unsigned bv);
    sb_t e;
    e.sum  = 9'(av + bv);
    e.segs = model_disp(av + bv);
    sb_q.push_back(e);
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    push(av, bv);
    tick();
    start = 1'b0;
  endtask

  // Compare seg against the expected pattern for whichever digit is lit now.
  task automatic check_lit(input logic [2:0][6:0] exp, input string tag);
    int unsigned idx;
    case (an)
      3'b110:  idx = 0;
      3'b101:  idx = 1;
      3'b011:  idx = 2;
      default: idx = 3;
    endcase
    chk("an_onehot", 32'(idx < 3), 32'd1);
    if (idx < 3) chk(tag, seg, exp[idx]);
  endtask

  // Entered in cycle k+1 (just after the edge that accepted start); returns in the done cycle.
  task automatic conv_check(input int unsigned poke, input logic [7:0] pa, input logic [7:0] pb);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=empty expected=entry");
      return;
    end
    e = sb_q[0];
    for (int unsigned c = 1; c <= 9; c++) begin
      if (c == 1) chk("sum_at_k1", sum, e.sum);
      chk("busy_conv", busy, 1);
      chk("done_conv", done, 0);
      check_lit(last_disp, "disp_hold");
      if (c == poke) begin
        start = 1'b1;
        a     = pa;
        b     = pb;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("busy_done", busy, 0);
    chk("done_pulse", done, 1);
    void'(sb_q.pop_front());
    chk("sum_done", sum, e.sum);
    last_disp = e.segs;
    check_lit(last_disp, "disp_new");
  endtask

  task automatic check_display(input logic [2:0][6:0] exp);
    logic [2:0] want;
    logic       found;
    for (int unsigned d = 0; d < 3; d++) begin
      want  = ~(3'b001 << d);
      found = 1'b0;
      for (int unsigned t = 0; t < 16; t++) begin
        if (an == want) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      if (found) begin
        chk("disp_digit", seg, exp[d]);
      end else begin
        checks++;
        errors++;
        $error("FAIL disp_an_timeout: observed=%0b expected=%0b", an, want);
      end
    end
  endtask

  initial begin
    last_disp = model_disp(0);

    // Reset held two edges with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd6;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, 7'b1000000);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    // Maximum sum, carry out set.
    start_op(8'd255, 8'd255);
    conv_check(0, 8'd0, 8'd0);
    tick();
    chk("done_single", done, 0);
    check_display(last_disp);

    // Small sum with leading-zero blanking.
    start_op(8'd3, 8'd4);
    conv_check(0, 8'd0, 8'd0);
    check_display(last_disp);

    // Interior zero.
    start_op(8'd100, 8'd5);
    conv_check(0, 8'd0, 8'd0);
    check_display(last_disp);

    // Start while busy is ignored; start in the done cycle is accepted.
    start_op(8'd10, 8'd20);
    conv_check(3, 8'd200, 8'd50);
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    push(1, 1);
    tick();
    start = 1'b0;
    conv_check(0, 8'd0, 8'd0);
    check_display(last_disp);

    // Reset mid-conversion, then idle scan from a known phase.
    start_op(8'd255, 8'd1);
    for (int unsigned c = 1; c <= 3; c++) begin
      chk("abort_busy", busy, 1);
      tick();
    end
    chk("abort_busy_k4", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb_q.pop_front());
    last_disp = model_disp(0);
    for (int unsigned c = 0; c < 16; c++) begin
      logic [2:0] exp_an;
      exp_an = ~(3'b001 << ((c / 4) % 3));
      chk("abort_busy_low", busy, 0);
      chk("abort_no_done", done, 0);
      chk("scan_an", an, exp_an);
      chk("scan_seg", seg, last_disp[(c / 4) % 3]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
